// File: rtl/spike_weight_streamer_if.sv
// ============================================================================
// Module      : spike_weight_streamer_if
// Description : Start/spike, weight-RAM read and OAAT stream signals of the
//               PIF neuron weight streamer. STREAMER_SPIKE_COUNT_EN adds spikeCount.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spike_weight_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUT  = 31,
    parameter int AW         = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
);
    logic                  start;
    logic [NUM_INPUT-1:0]  spikeIn;
    logic                  busy;
    logic [AW-1:0]         weightAddr;
    logic                  weightRen;
    logic [DATA_WIDTH-1:0] weightRdata;
    logic [DATA_WIDTH-1:0] weightData;
    logic                  weightValid;
    logic                  updateEnable;
    logic                  done;
`ifdef STREAMER_SPIKE_COUNT_EN
    logic [AW:0]           spikeCount;
`endif

    modport master (
        input  start, spikeIn, weightRdata,
        output busy, weightAddr, weightRen, weightData, weightValid,
`ifdef STREAMER_SPIKE_COUNT_EN
        output spikeCount,
`endif
        output updateEnable, done
    );

    modport slave (
        output start, spikeIn, weightRdata,
        input  busy, weightAddr, weightRen, weightData, weightValid,
`ifdef STREAMER_SPIKE_COUNT_EN
        input  spikeCount,
`endif
        input  updateEnable, done
    );
endinterface

`default_nettype wire

// File: rtl/spike_weight_streamer.sv
// ============================================================================
// Module      : spike_weight_streamer
// Description : OAAT weight-sum transmitter: streams one weight (or zero) per
//               synapse, then pulses updateEnable. Option: STREAMER_SPIKE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_weight_streamer #(
    parameter int INTEGER_WIDTH   = 16,
    parameter int DATA_WIDTH_FRAC = 0,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int NUM_INPUT       = 31,
    parameter int ACC_LATENCY     = 1,
    parameter int AW              = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    spike_weight_streamer_if.master  bus
);

    localparam int CW = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_INPUT - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((ACC_LATENCY > 0) ? ACC_LATENCY - 1 : 0);
`ifdef STREAMER_SPIKE_COUNT_EN
    localparam bit GATE_REN = 1'b1;
`else
    localparam bit GATE_REN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DRAIN  = 3'd2,
        WAIT   = 3'd3,
        UPDATE = 3'd4
    } state_t;

    state_t               state;
    logic [NUM_INPUT-1:0] spike_latch;
    logic [AW-1:0]        addr;
    logic [CW-1:0]        wait_cnt;
    logic                 fetching;
    logic                 ren;
    logic                 valid;
    logic                 word_on;
    logic                 busy;
    logic                 upd;
    logic                 done;
    logic                 holdoff;

`ifdef STREAMER_SPIKE_COUNT_EN
    logic [AW:0] spike_count;

    function automatic logic [AW:0] popcount(input logic [NUM_INPUT-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            spike_latch <= '0;
            addr        <= '0;
            wait_cnt    <= '0;
            fetching    <= 1'b0;
            ren         <= 1'b0;
            valid       <= 1'b0;
            word_on     <= 1'b0;
            busy        <= 1'b0;
            upd         <= 1'b0;
            done        <= 1'b0;
            holdoff     <= 1'b0;
`ifdef STREAMER_SPIKE_COUNT_EN
            spike_count <= '0;
`endif
        end else begin
            // RAM data lands one cycle after the read, so the stream lags fetch by one.
            valid   <= fetching;
            word_on <= fetching && spike_latch[addr];
            case (state)
                IDLE: begin
                    // One dead cycle after UPDATE sets the back-to-back period.
                    if (holdoff) begin
                        holdoff <= 1'b0;
                    end else if (bus.start) begin
                        spike_latch <= bus.spikeIn;
                        addr        <= '0;
                        busy        <= 1'b1;
                        fetching    <= 1'b1;
                        ren         <= !GATE_REN || bus.spikeIn[0];
                        state       <= FETCH;
`ifdef STREAMER_SPIKE_COUNT_EN
                        spike_count <= popcount(bus.spikeIn);
`endif
                    end
                end
                FETCH: begin
                    if (addr == LAST_ADDR) begin
                        fetching <= 1'b0;
                        ren      <= 1'b0;
                        state    <= DRAIN;
                    end else begin
                        addr <= addr + 1'b1;
                        ren  <= !GATE_REN || spike_latch[addr + 1'b1];
                    end
                end
                DRAIN: begin
                    if (ACC_LATENCY == 0) begin
                        upd   <= 1'b1;
                        done  <= 1'b1;
                        state <= UPDATE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        upd   <= 1'b1;
                        done  <= 1'b1;
                        state <= UPDATE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                UPDATE: begin
                    upd     <= 1'b0;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    holdoff <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy;
    assign bus.weightAddr   = addr;
    assign bus.weightRen    = ren;
    assign bus.weightValid  = valid;
    assign bus.weightData   = word_on ? bus.weightRdata : '0;
    assign bus.updateEnable = upd;
    assign bus.done         = done;
`ifdef STREAMER_SPIKE_COUNT_EN
    assign bus.spikeCount   = spike_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spike_weight_streamer.sv
// ============================================================================
// Module      : tb_spike_weight_streamer
// Description : Scoreboard bench for spike_weight_streamer (N=4, ACC_LATENCY=1),
//               also covers STREAMER_SPIKE_COUNT_EN builds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_weight_streamer;
    localparam int N   = 4;
    localparam int ACC = 1;
    localparam int DW  = 16;
    localparam int AW  = 2;
    localparam int P   = N + 4 + ACC;
`ifdef STREAMER_SPIKE_COUNT_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    spike_weight_streamer_if #(.DATA_WIDTH(DW), .NUM_INPUT(N), .AW(AW)) bus ();

    spike_weight_streamer #(
        .INTEGER_WIDTH(16), .DATA_WIDTH_FRAC(0), .DATA_WIDTH(DW),
        .NUM_INPUT(N), .ACC_LATENCY(ACC), .AW(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] ram [N];
    always @(posedge clk) if (bus.weightRen) bus.weightRdata <= ram[bus.weightAddr];

    typedef struct { int cyc; logic [DW-1:0] data; } word_t;
    typedef struct { int cyc; int addr; } ren_t;
    word_t exp_words[$];
    ren_t  exp_ren[$];
    int    exp_upd[$];
    int    busy_lo[$];
    int    busy_hi[$];
    int    exp_cnt_val = 0;
    int    exp_cnt_cyc = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: start seen in cycle T gives word i at T+2+i, read i at T+1+i,
    // update at T+N+2+ACC, busy over [T+1, T+N+2+ACC].
    task automatic schedule(input int t, input logic [N-1:0] spk);
        word_t w;
        ren_t  r;
        for (int i = 0; i < N; i++) begin
            w.cyc  = t + 2 + i;
            w.data = spk[i] ? ram[i] : '0;
            exp_words.push_back(w);
            if (!GATE || spk[i]) begin
                r.cyc  = t + 1 + i;
                r.addr = i;
                exp_ren.push_back(r);
            end
        end
        exp_upd.push_back(t + N + 2 + ACC);
        busy_lo.push_back(t + 1);
        busy_hi.push_back(t + N + 2 + ACC);
        exp_cnt_val = $countones(spk);
        exp_cnt_cyc = t + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input logic [N-1:0] spk, input bit poke);
        schedule(cyc, spk);
        bus.start   = 1'b1;
        bus.spikeIn = spk;
        tick();
        bus.start   = 1'b0;
        bus.spikeIn = N'($urandom);
        tick();
        if (poke) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            repeat (P - 3) tick();
        end else begin
            repeat (P - 2) tick();
        end
    endtask

    always @(negedge clk) begin
        word_t w;
        ren_t  r;
        int    u;
        bit    exp_busy;
        if (reset) begin
            if (bus.weightValid) begin
                if (exp_words.size() == 0) begin
                    check(1'b0, "unexpected_word", longint'(bus.weightData), 0);
                end else begin
                    w = exp_words.pop_front();
                    check(w.cyc == cyc, "word_cycle", cyc, w.cyc);
                    check(bus.weightData == w.data, "word_data", longint'(bus.weightData), longint'(w.data));
                end
            end else begin
                check(bus.weightData == '0, "idle_data_zero", longint'(bus.weightData), 0);
            end
            if (bus.weightRen) begin
                if (exp_ren.size() == 0) begin
                    check(1'b0, "unexpected_ren", longint'(bus.weightAddr), -1);
                end else begin
                    r = exp_ren.pop_front();
                    check(r.cyc == cyc, "ren_cycle", cyc, r.cyc);
                    check(int'(bus.weightAddr) == r.addr, "ren_addr", longint'(bus.weightAddr), r.addr);
                end
            end
            if (bus.updateEnable) begin
                if (exp_upd.size() == 0) begin
                    check(1'b0, "unexpected_update", cyc, -1);
                end else begin
                    u = exp_upd.pop_front();
                    check(u == cyc, "update_cycle", cyc, u);
                end
                check(bus.done == 1'b1, "done_with_update", longint'(bus.done), 1);
            end else begin
                check(bus.done == 1'b0, "done_alone", longint'(bus.done), 0);
            end
            while (busy_hi.size() > 0 && busy_hi[0] < cyc) begin
                void'(busy_lo.pop_front());
                void'(busy_hi.pop_front());
            end
            exp_busy = (busy_lo.size() > 0) && (busy_lo[0] <= cyc);
            check(bus.busy == exp_busy, "busy", longint'(bus.busy), longint'(exp_busy));
`ifdef STREAMER_SPIKE_COUNT_EN
            if (cyc >= exp_cnt_cyc)
                check(int'(bus.spikeCount) == exp_cnt_val, "spike_count", longint'(bus.spikeCount), exp_cnt_val);
`endif
        end
    end

    task automatic check_all_zero(input string tag);
        check(bus.busy == 1'b0,         {tag, "_busy"},  longint'(bus.busy), 0);
        check(bus.weightRen == 1'b0,    {tag, "_ren"},   longint'(bus.weightRen), 0);
        check(bus.weightAddr == '0,     {tag, "_addr"},  longint'(bus.weightAddr), 0);
        check(bus.weightValid == 1'b0,  {tag, "_valid"}, longint'(bus.weightValid), 0);
        check(bus.weightData == '0,     {tag, "_data"},  longint'(bus.weightData), 0);
        check(bus.updateEnable == 1'b0, {tag, "_upd"},   longint'(bus.updateEnable), 0);
        check(bus.done == 1'b0,         {tag, "_done"},  longint'(bus.done), 0);
`ifdef STREAMER_SPIKE_COUNT_EN
        check(bus.spikeCount == '0,     {tag, "_count"}, longint'(bus.spikeCount), 0);
`endif
    endtask

    initial begin
        logic [N-1:0] spk;
        int t0;
        bus.start       = 1'b0;
        bus.spikeIn     = '0;
        bus.weightRdata = '0;
        ram[0] = 16'd5; ram[1] = 16'hFFFD; ram[2] = 16'd7; ram[3] = 16'd2;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) tick();

        run_stream(4'b1011, 1'b0);           // words 5,-3,0,2
        run_stream(4'b0000, 1'b0);           // all-silent stream
        run_stream(4'b0110, 1'b1);           // start pulsed during FETCH

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
            case ($urandom_range(4, 0))
                0:       spk = '0;
                1:       spk = '1;
                default: spk = N'($urandom);
            endcase
            run_stream(spk, 1'($urandom_range(1, 0)));
            repeat ($urandom_range(2, 0)) tick();
        end

        // start held high across three streams
        spk = 4'b1101;
        t0  = cyc;
        for (int k = 0; k < 3; k++) schedule(t0 + k * P, spk);
        bus.start   = 1'b1;
        bus.spikeIn = spk;
        repeat (2 * P + 1) tick();
        bus.start = 1'b0;
        repeat (P) tick();

        // reset in the middle of FETCH abandons the stream
        schedule(cyc, 4'b1111);
        bus.start   = 1'b1;
        bus.spikeIn = 4'b1111;
        tick();
        bus.start = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_words.delete();
        exp_ren.delete();
        exp_upd.delete();
        busy_lo.delete();
        busy_hi.delete();
        exp_cnt_val = 0;
        exp_cnt_cyc = cyc;
        tick();
        reset = 1'b1;
        tick();
        run_stream(4'b1001, 1'b0);

        repeat (10) tick();
        check(exp_words.size() == 0, "words_left", exp_words.size(), 0);
        check(exp_ren.size() == 0,   "reads_left", exp_ren.size(), 0);
        check(exp_upd.size() == 0,   "updates_left", exp_upd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
